// File: rtl/operand_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_reader_pkg
// Purpose  : Shared states, slot tags and operand width for operand_reader.
// Revision : 1.0
// ============================================================================
package operand_reader_pkg;

    localparam int OPERAND_W = 8;

    localparam logic [1:0] SLOT_A   = 2'd0;
    localparam logic [1:0] SLOT_B   = 2'd1;
    localparam logic [1:0] SLOT_SUM = 2'd2;

`ifdef SUM_BEAT_EN
    localparam logic [1:0] SLOT_LAST = SLOT_SUM;
`else
    localparam logic [1:0] SLOT_LAST = SLOT_B;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/operand_reader_request_edge.sv
`default_nettype none
// ============================================================================
// Module   : request_edge
// Purpose  : Registers the active-low request and emits a one-cycle start
//            pulse on its falling edge.
// Revision : 1.0
// ============================================================================
module request_edge (
    input  logic clock,
    input  logic reset,
    input  logic request,
    output logic start
);

    logic r_prev;
    logic r_start;

    // Previous value resets high so a request already low at release starts a read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev  <= 1'b1;
            r_start <= 1'b0;
        end else begin
            r_prev  <= request;
            r_start <= r_prev & ~request;
        end
    end

    assign start = r_start;

endmodule
`default_nettype wire

// File: rtl/operand_reader.sv
`default_nettype none
// ============================================================================
// Module   : operand_reader
// Purpose  : Snapshots a two-operand store on a request edge and streams the
//            operands as valid/ready beats; SUM_BEAT_EN adds an A+B beat.
// Revision : 1.0
// ============================================================================
module operand_reader
    import operand_reader_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          storedVals,
    input  logic                 request,
    output logic [OPERAND_W-1:0] dataOut,
    output logic [1:0]           slotId,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 busy,
    output logic                 carryOut
);

    localparam logic [3:0] c_gap_load = 4'(GAP_CYCLES - 1);

    state_t                 r_state;
    logic [15:0]            r_snap;
    logic [1:0]             r_beat;
    logic [3:0]             r_gap;
    logic [OPERAND_W-1:0]   r_data;
    logic [1:0]             r_slot;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_carry;

    logic                   w_start;
    logic [1:0]             w_sel;
    logic [OPERAND_W-1:0]   w_word;
    logic                   w_carry;

    request_edge u_request_edge (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .start   (w_start)
    );

    // Beat to present next: already advanced while in GAP, one ahead while in SEND.
    always_comb begin
        w_sel   = (r_state == GAP) ? r_beat : r_beat + 2'd1;
        w_carry = 1'b0;
        case (w_sel)
            SLOT_A:  w_word = r_snap[15:8];
            default: w_word = r_snap[7:0];
        endcase
`ifdef SUM_BEAT_EN
        if (w_sel == SLOT_SUM) begin
            {w_carry, w_word} = {1'b0, r_snap[15:8]} + {1'b0, r_snap[7:0]};
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_beat  <= SLOT_A;
            r_gap   <= '0;
            r_data  <= '0;
            r_slot  <= SLOT_A;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_snap  <= storedVals;
                    r_beat  <= SLOT_A;
                    r_data  <= storedVals[15:8];
                    r_slot  <= SLOT_A;
                    r_carry <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= SEND;
                end
                SEND: begin
                    if (dataReady) begin
                        if (r_beat == SLOT_LAST) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_carry <= 1'b0;
                            r_state <= DONE;
                        end else if (GAP_CYCLES == 0) begin
                            r_beat  <= w_sel;
                            r_data  <= w_word;
                            r_slot  <= w_sel;
                            r_carry <= w_carry;
                        end else begin
                            r_beat  <= w_sel;
                            r_valid <= 1'b0;
                            r_gap   <= c_gap_load;
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == 4'd0) begin
                        r_data  <= w_word;
                        r_slot  <= w_sel;
                        r_carry <= w_carry;
                        r_valid <= 1'b1;
                        r_state <= SEND;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dataOut   = r_data;
    assign slotId    = r_slot;
    assign dataValid = r_valid;
    assign busy      = r_busy;
    assign carryOut  = r_carry;

endmodule
`default_nettype wire
